// File: rtl/seg7_pkg.sv
// Shared types and constants for the multi-digit 7-segment driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_UPDATE
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Smallest r with 2**r >= n.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Nibble to active-low 7-segment pattern; dash overrides blank.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    if (dash) begin
      seg_n = SEG_DASH;
    end else if (blank) begin
      seg_n = SEG_BLANK;
    end else begin
      unique case (nibble)
        4'h0: seg_n = 7'h40;
        4'h1: seg_n = 7'h79;
        4'h2: seg_n = 7'h24;
        4'h3: seg_n = 7'h30;
        4'h4: seg_n = 7'h19;
        4'h5: seg_n = 7'h12;
        4'h6: seg_n = 7'h02;
        4'h7: seg_n = 7'h78;
        4'h8: seg_n = 7'h00;
        4'h9: seg_n = 7'h10;
        4'hA: seg_n = 7'h08;
        4'hB: seg_n = 7'h03;
        4'hC: seg_n = 7'h46;
        4'hD: seg_n = 7'h21;
        4'hE: seg_n = 7'h06;
        4'hF: seg_n = 7'h0E;
        default: seg_n = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_multi_display.sv
// Multi-digit 7-segment driver: serial binary-to-BCD (shift-and-add-3) or hex
// pass-through, leading-zero blanking, overflow dashes, registered outputs.
module seg7_multi_display
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned VALUE_W = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VALUE_W-1:0]    value_in,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg_n
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (clog2(VALUE_W) > 0) ? clog2(VALUE_W) : 1;
  localparam int unsigned EXT_W = (VALUE_W > BCD_W) ? VALUE_W : BCD_W;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VALUE_W - 1);

  state_e               state_q, state_d;
  logic [VALUE_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]     step_q, step_d;
  logic                 hex_q, hex_d;
  logic                 blz_q, blz_d;
  logic                 ovf_acc_q, ovf_acc_d;
  logic [7*DIGITS-1:0]  seg_q, seg_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic [BCD_W-1:0]     bcd_adj;
  logic [EXT_W-1:0]     ext;
  logic                 disp_ovf;
  logic [3:0]           nib [DIGITS];
  logic [DIGITS-1:0]    blank_vec;
  logic [7*DIGITS-1:0]  glyph_seg;

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Hex path keeps the captured value untouched in shift_q.
  always_comb begin
    logic lead_zero;
    ext       = EXT_W'(shift_q);
    disp_ovf  = hex_q ? (|(ext >> BCD_W)) : ovf_acc_q;
    lead_zero = 1'b1;
    blank_vec = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      nib[k] = hex_q ? ext[4*k +: 4] : bcd_q[4*k +: 4];
    end
    for (int unsigned j = 0; j < DIGITS; j++) begin
      lead_zero                 = lead_zero & (nib[DIGITS-1-j] == 4'd0);
      blank_vec[DIGITS-1-j]     = blz_q & lead_zero & ((DIGITS - 1 - j) != 0);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_glyph u_glyph (
      .nibble (nib[g]),
      .blank  (blank_vec[g]),
      .dash   (disp_ovf),
      .seg_n  (glyph_seg[7*g +: 7])
    );
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    step_d    = step_q;
    hex_d     = hex_q;
    blz_d     = blz_q;
    ovf_acc_d = ovf_acc_q;
    seg_d     = seg_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          shift_d   = value_in;
          hex_d     = hex_mode;
          blz_d     = blank_lz;
          bcd_d     = '0;
          step_d    = '0;
          ovf_acc_d = 1'b0;
          state_d   = hex_mode ? ST_UPDATE : ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        bcd_d     = {bcd_adj[BCD_W-2:0], shift_q[VALUE_W-1]};
        ovf_acc_d = ovf_acc_q | bcd_adj[BCD_W-1];
        shift_d   = shift_q << 1;
        step_d    = step_q + CNT_W'(1);
        if (step_q == LAST_STEP) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        seg_d   = glyph_seg;
        ovf_d   = disp_ovf;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      step_q    <= '0;
      hex_q     <= 1'b0;
      blz_q     <= 1'b0;
      ovf_acc_q <= 1'b0;
      seg_q     <= '1;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      step_q    <= step_d;
      hex_q     <= hex_d;
      blz_q     <= blz_d;
      ovf_acc_q <= ovf_acc_d;
      seg_q     <= seg_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign seg_n    = seg_q;

endmodule
